// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed common-anode 7-seg driver.
// Ports: clk, rst_n (async low), load/digits/dp_in/digit_en (capture),
//   seg/dp/an (active-low pins), update_pending, frame_done.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    update_pending,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        g = 7'h7F;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic       tick;
    logic       boundary;
    logic       lit;
    logic [3:0] cur_nib;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dropped while every enabled digit above it reads zero;
    // digit 0 and digits with a lit decimal point always show.
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  upper_zero;

    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (act_en_q[k] && (act_dig_q[4*k +: 4] == 4'h0)
                && !act_dp_q[k] && upper_zero) begin
                lz_blank[k] = 1'b1;
            end
            if (act_en_q[k] && (act_dig_q[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end
`endif

    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        boundary = tick && (idx_q == IDX_LAST);

        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_en_d  = pend_en_q;
        pend_d     = pend_q;
        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;

        if (load) begin
            pend_dig_d = digits;
            pend_dp_d  = dp_in;
            pend_en_d  = digit_en;
            pend_d     = 1'b1;
        end

        // A load on the boundary bypasses the shadow and is shown at once.
        if (boundary) begin
            if (load) begin
                act_dig_d = digits;
                act_dp_d  = dp_in;
                act_en_d  = digit_en;
            end else if (pend_q) begin
                act_dig_d = pend_dig_q;
                act_dp_d  = pend_dp_q;
                act_en_d  = pend_en_q;
            end
            pend_d = 1'b0;
        end

        cur_nib = act_dig_q[{idx_q, 2'b00} +: 4];
        lit     = act_en_q[idx_q] && (presc_q >= BLANK_END);
`ifdef LEADING_ZERO_BLANK_EN
        if (lz_blank[idx_q]) begin
            lit = 1'b0;
        end
`endif

        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = !(lit && (idx_q == IW'(k)));
        end
        seg_d = lit ? glyph(cur_nib) : 7'h7F;
        dp_d  = lit ? !act_dp_q[idx_q] : 1'b1;
        fd_d  = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_en_q  <= '0;
            pend_q     <= 1'b0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_en_q  <= pend_en_d;
            pend_q     <= pend_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign seg            = seg_q;
    assign dp             = dp_q;
    assign an             = an_q;
    assign update_pending = pend_q;
    assign frame_done     = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: scoreboard bench for seven_segment_scanner.
// Cycle-arithmetic reference model feeds a queue; a monitor compares.
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FR = ND * RD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [4*ND-1:0] digits = '0;
    logic [ND-1:0] dp_in = '0;
    logic [ND-1:0] digit_en = '0;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          update_pending;
    logic          frame_done;

    int checks = 0;
    int failures = 0;

    seven_segment_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .digits        (digits),
        .dp_in         (dp_in),
        .digit_en      (digit_en),
        .seg           (seg),
        .dp            (dp),
        .an            (an),
        .update_pending(update_pending),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
        logic          upd;
        logic          fd;
    } obs_t;

    obs_t exp_q[$];

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: edges since reset release, displayed and waiting data.
    int              e = 0;
    logic [4*ND-1:0] m_act_dig = '0;
    logic [ND-1:0]   m_act_dp = '0;
    logic [ND-1:0]   m_act_en = '0;
    logic [4*ND-1:0] m_pnd_dig = '0;
    logic [ND-1:0]   m_pnd_dp = '0;
    logic [ND-1:0]   m_pnd_en = '0;
    bit              m_pend = 0;

    function automatic int nib_of(int ix);
        return int'((m_act_dig >> (4 * ix)) & 16'hF);
    endfunction

    function automatic bit above_all_zero(int ix);
        bit z;
        z = 1;
        for (int j = ix + 1; j < ND; j++)
            if (m_act_en[j] && nib_of(j) != 0) z = 0;
        return z;
    endfunction

    function automatic obs_t slot_view(int p, int ix);
        obs_t o;
        bit on;
        o.an  = '1;
        o.seg = 7'h7F;
        o.dp  = 1'b1;
        o.upd = 1'b0;
        o.fd  = 1'b0;
        on = (p >= BC) && m_act_en[ix];
`ifdef LEADING_ZERO_BLANK_EN
        if (ix > 0 && nib_of(ix) == 0 && !m_act_dp[ix]
            && above_all_zero(ix)) on = 0;
`endif
        if (on) begin
            o.an[ix] = 1'b0;
            o.seg    = glyph_tab[nib_of(ix)];
            o.dp     = !m_act_dp[ix];
        end
        return o;
    endfunction

    // Reference model: outputs after edge e reflect the slot that was
    // running before it; frame boundaries are every FR-th edge.
    initial forever begin
        obs_t x;
        bit bnd;
        @(posedge clk);
        if (!rst_n) begin
            e = 0;
            m_act_dig = '0; m_act_dp = '0; m_act_en = '0;
            m_pnd_dig = '0; m_pnd_dp = '0; m_pnd_en = '0;
            m_pend = 0;
            x.an = '1; x.seg = 7'h7F; x.dp = 1'b1;
            x.upd = 1'b0; x.fd = 1'b0;
        end else begin
            e++;
            x = slot_view((e - 1) % RD, ((e - 1) / RD) % ND);
            bnd = (e % FR) == 0;
            if (bnd) begin
                if (load) begin
                    m_act_dig = digits; m_act_dp = dp_in;
                    m_act_en = digit_en;
                end else if (m_pend) begin
                    m_act_dig = m_pnd_dig; m_act_dp = m_pnd_dp;
                    m_act_en = m_pnd_en;
                end
                m_pend = 0;
            end else if (load) begin
                m_pnd_dig = digits; m_pnd_dp = dp_in;
                m_pnd_en = digit_en;
                m_pend = 1;
            end
            x.upd = m_pend;
            x.fd  = bnd;
        end
        exp_q.push_back(x);
    end

    initial forever begin
        obs_t x;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== {x.an, x.seg, x.dp}) begin
                failures++;
                $display("FAIL pins t=%0t an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         $time, an, seg, dp, x.an, x.seg, x.dp);
            end
            checks++;
            if ({update_pending, frame_done} !== {x.upd, x.fd}) begin
                failures++;
                $display("FAIL flags t=%0t pend=%b fd=%b want pend=%b fd=%b",
                         $time, update_pending, frame_done, x.upd, x.fd);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] en);
        load = 1'b1; digits = d; dp_in = p; digit_en = en;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Park on the negedge right before a frame-boundary edge.
    task automatic align_boundary();
        for (int i = 0; i < FR + 2 && ((e + 1) % FR) != 0; i++)
            @(negedge clk);
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Basic scan of F821 with dp on digit 2.
        do_load(16'hF821, 4'b0100, 4'hF);
        idle(2 * FR + 3);

        // Glitch-free update: 1111 at the boundary, AAAA mid-frame.
        align_boundary();
        do_load(16'h1111, 4'b0000, 4'hF);
        idle(5);
        do_load(16'hAAAA, 4'b0000, 4'hF);
        idle(2 * FR);

        // Load coinciding with the boundary.
        align_boundary();
        do_load(16'h0000, 4'b0000, 4'hF);
        idle(FR + 2);

        // Disabled digits 1 and 3.
        do_load(16'h5A3C, 4'b1111, 4'b0101);
        idle(3 * FR);

        // Leading-zero pattern (plain zeros unless blanking is built in).
        do_load(16'h0070, 4'b0000, 4'hF);
        idle(2 * FR);
        do_load(16'h0000, 4'b0000, 4'hF);
        idle(2 * FR);

        // Asynchronous reset mid-slot with a load still pending.
        align_boundary();
        idle(3);
        do_load(16'h9876, 4'b0011, 4'hF);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1
            || update_pending !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset an=%b seg=%b dp=%b pend=%b fd=%b want 1111/1111111/1/0/0",
                     an, seg, dp, update_pending, frame_done);
        end
        idle(3);
        rst_n = 1'b1;
        idle(FR + 2);

        // Randomized loads, including some at frame boundaries.
        for (int i = 0; i < 1200; i++) begin
            load     = ($urandom_range(0, 9) == 0);
            digits   = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            @(negedge clk);
        end
        load = 1'b0;
        idle(2 * FR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
